// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-memory write port
// Signals:
//   in_valid/in_data/in_ready   byte stream, transfer on in_valid && in_ready
//   mem_we/mem_addr/mem_wdata   one-cycle word write strobe, word address, data
// Modports: master drives the stream and observes writes; slave is the loader.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader assembling big-endian words into instruction memory
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     byte stream in, instruction-memory write port out
//   i_reload        synchronous restart of the load, re-asserts o_cpu_rst
//   o_cpu_rst       processor reset, high until the image is loaded
//   o_done          image loaded, processor released
//   o_error         sticky load failure
//   o_word_count    words written so far
// Option: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte (CHK state).
module imem_loader #(parameter int ADDR_W = 8) (
  input  logic clk,
  input  logic rst_n,
  imem_loader_if.slave bus,
  input  logic i_reload,
  output logic o_cpu_rst,
  output logic o_done,
  output logic o_error,
  output logic [15:0] o_word_count
);
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;
  state_t r_state;
  logic [15:0] r_len;
  logic [1:0] r_cnt;
  logic [23:0] r_shift;
  logic r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata;
  logic r_cpu_rst;
  logic r_done;
  logic r_error;
  logic [15:0] r_wc;
  logic w_hs;
  logic [15:0] w_len;
  logic w_too_long;
  logic w_last;
  assign bus.in_ready = r_state != S_DONE && r_state != S_ERR;
  assign w_hs = bus.in_valid && bus.in_ready;
  assign w_len = {r_len[15:8], bus.in_data};
  assign w_too_long = {1'b0, w_len} > MAX_N;
  assign w_last = r_wc + 16'd1 == r_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_csum;
  assign w_csum = r_sum + bus.in_data;
`endif
  // done/cpu_rst follow the state one edge late so the final write lands first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LEN_HI;
      r_len <= '0;
      r_cnt <= '0;
      r_shift <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_cpu_rst <= 1'b1;
      r_done <= 1'b0;
      r_error <= 1'b0;
      r_wc <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      r_done <= r_state == S_DONE;
      r_cpu_rst <= r_state != S_DONE;
      if (i_reload) begin
        r_state <= S_LEN_HI;
        r_cnt <= '0;
        r_wc <= '0;
        r_done <= 1'b0;
        r_error <= 1'b0;
        r_cpu_rst <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum <= '0;
`endif
      end else if (w_hs) begin
        case (r_state)
          S_LEN_HI: begin
            r_len[15:8] <= bus.in_data;
            r_state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len[7:0] <= bus.in_data;
            r_error <= w_too_long;
            r_state <= w_too_long ? S_ERR : w_len == 16'd0 ? S_FIN : S_DATA;
          end
          S_DATA: begin
            r_cnt <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], bus.in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= w_csum;
`endif
            if (r_cnt == 2'd3) begin
              r_we <= 1'b1;
              r_addr <= r_wc[ADDR_W-1:0];
              r_wdata <= {r_shift, bus.in_data};
              r_wc <= r_wc + 16'd1;
              if (w_last) r_state <= S_FIN;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            r_error <= w_csum != 8'd0;
            r_state <= w_csum == 8'd0 ? S_DONE : S_ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end
  assign bus.mem_we = r_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_cpu_rst = r_cpu_rst;
  assign o_done = r_done;
  assign o_error = r_error;
  assign o_word_count = r_wc;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into the instruction memory's write port and holds the processor in reset until the image is complete. It sits directly upstream of the processor's instruction memory and replaces the simulation-only hex preload for synthesizable boot.

## Interface
- ADDR_W, 8, word-address width of instruction memory; capacity 2^ADDR_W words
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reload  in  1  synchronous pulse: abort/restart load, re-assert cpu_rst
- in_valid  in  1  byte available
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address (word index, not byte address)
- mem_wdata  out  32  assembled word
- cpu_rst  out  1  active-high reset to processor; high until load succeeds
- done  out  1  image loaded, processor released
- error  out  1  load failed; sticky until reload or rst_n
- word_count  out  16  words written so far

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes, MSB of each word first.
- States: LEN_HI → LEN_LO → DATA → DONE; ERR reachable from LEN_LO; CHK inserted before DONE when the checksum option is enabled.
- Byte accepted only on in_valid && in_ready. in_ready = 1 in LEN_HI, LEN_LO, DATA and CHK; 0 in DONE and ERR.
- LEN_LO accept: if N > 2^ADDR_W → ERR. If N == 0 → DONE (or CHK). Otherwise → DATA.
- DATA: 2-bit byte counter shifts bytes into a 32-bit assembly register. The 4th byte triggers a write at address word_count, then word_count increments.
- Last byte of word N−1 → DONE (or CHK).
- DONE: cpu_rst = 0, done = 1; further stream bytes are ignored (in_ready = 0).
- ERR: error = 1, cpu_rst = 1, done = 0.
- reload (any state): on the next edge go to LEN_HI and clear word_count, byte counter, done, error and checksum; cpu_rst = 1. If reload and a byte handshake coincide, reload wins and the byte is discarded.
- in_valid is ignored while in_ready = 0. in_data is sampled only on handshake.

## Timing
- Reset values (rst_n low, asynchronous): state LEN_HI, in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 1, done 0, error 0, word_count 0.
- mem_we, mem_addr and mem_wdata are registered. The 4th byte accepted at edge k produces mem_we = 1 in the cycle after edge k, and 0 after edge k+1.
- word_count updates at the same edge k.
- Final word: state goes to DONE at edge k. done rises and cpu_rst falls at edge k+1, so the last memory write lands before the processor leaves reset.
- N == 0: done rises one cycle after the LEN_LO accept edge.
- One byte per cycle sustained; no bubbles are inserted by the loader.
- rst_n assertion mid-load aborts immediately. Partially written memory contents are left as-is.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the data bytes, CHK state accepts one byte C.
  - The load passes if (sum of all 4·N data bytes + C) mod 256 == 0.
  - Pass: DONE with the same +1 cycle timing, measured from the C accept edge.
  - Fail: ERR.
  - The length bytes are excluded from the sum.
- Not defined: no CHK state; the stream ends after the last data byte, and no checksum logic is built.

## Test plan
- Load N = 3 with words 0x20080005, 0x2009000A, 0x01095020 at one byte/cycle. Required:
  - three mem_we pulses at addr 0, 1, 2 with exact data;
  - done = 1 and cpu_rst = 0 one cycle after the last write strobe;
  - word_count = 3.
- Same image with in_valid toggling 1/0 every cycle. Required: identical writes and data, with done later.
- Header N = 0x0101 with ADDR_W = 8. Required: error = 1 after the LEN_LO accept, in_ready = 0, cpu_rst stays 1, mem_we is never asserted.
- reload asserted after 6 data bytes, then a full N = 1 image of 0xDEADBEEF. Required:
  - error/done cleared and word_count reset to 0;
  - a single write of 0xDEADBEEF at addr 0;
  - done = 1.
- rst_n pulsed low mid-word. Required: all outputs return to reset values asynchronously, and a subsequent full load succeeds.
- With IMEM_LOADER_CHECKSUM_EN, N = 1 word 0x01020304:
  - C = 0xF6 → done = 1;
  - C = 0xF7 → error = 1 and cpu_rst = 1.
